// File: rtl/main_fsm.sv
// Multicycle control FSM for the rv32i core: sequences fetch/decode/execute/writeback per opcode.
// Optional feature: define RV_JAL_EN to decode op 111 (jal) into the JAL state.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       memReady,
  output logic [3:0] state,
  output logic       pcUpdate,
  output logic       irWrite,
  output logic       branch,
  output logic       regWrite,
  output logic       memWrite,
  output logic       adrSrc,
  output logic [1:0] resSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] inmSrc,
  output logic       illegalOp
);

  localparam logic [6:0] OpLoad  = 7'd3;
  localparam logic [6:0] OpImm   = 7'd19;
  localparam logic [6:0] OpStore = 7'd35;
  localparam logic [6:0] OpReg   = 7'd51;
  localparam logic [6:0] OpBeq   = 7'd99;
  localparam logic [6:0] OpJal   = 7'd111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_e;

  state_e r_state;
  state_e w_next;

  logic w_pc_update;
  logic w_ir_write;
  logic w_branch;
  logic w_reg_write;
  logic w_mem_write;
  logic w_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = StFetch;
    w_pc_update = 1'b0;
    w_ir_write  = 1'b0;
    w_branch    = 1'b0;
    w_reg_write = 1'b0;
    w_mem_write = 1'b0;
    w_illegal   = 1'b0;
    adrSrc      = 1'b0;
    resSrc      = 2'b00;
    aluSrcA     = 2'b00;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;

    case (r_state)
      StFetch: begin
        aluSrcB     = 2'b10;
        resSrc      = 2'b10;
        w_ir_write  = memReady;
        w_pc_update = memReady;
        w_next      = memReady ? StDecode : StFetch;
      end
      StDecode: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (op)
          OpLoad, OpStore: w_next = StMemAdr;
          OpReg:           w_next = StExecR;
          OpImm:           w_next = StExecI;
          OpBeq:           w_next = StBeq;
`ifdef RV_JAL_EN
          OpJal:           w_next = StJal;
`endif
          default: begin
            w_illegal = 1'b1;
            w_next    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        w_next  = (op == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        adrSrc = 1'b1;
        w_next = memReady ? StMemWb : StMemRead;
      end
      StMemWb: begin
        resSrc      = 2'b01;
        w_reg_write = 1'b1;
      end
      StMemWrite: begin
        // Request stays up every cycle until memory accepts it.
        adrSrc      = 1'b1;
        w_mem_write = 1'b1;
        w_next      = memReady ? StFetch : StMemWrite;
      end
      StExecR: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
        w_next  = StAluWb;
      end
      StExecI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = 2'b10;
        w_next  = StAluWb;
      end
`ifdef RV_JAL_EN
      StJal: begin
        aluSrcA     = 2'b01;
        aluSrcB     = 2'b10;
        w_pc_update = 1'b1;
        w_next      = StAluWb;
      end
`endif
      StAluWb: begin
        w_reg_write = 1'b1;
      end
      StBeq: begin
        aluSrcA  = 2'b10;
        aluOp    = 2'b01;
        w_branch = 1'b1;
      end
      default: w_next = StFetch;
    endcase
  end

  always_comb begin
    case (op)
      OpStore: inmSrc = 2'b01;
      OpBeq:   inmSrc = 2'b10;
`ifdef RV_JAL_EN
      OpJal:   inmSrc = 2'b11;
`endif
      default: inmSrc = 2'b00;
    endcase
  end

  // Strobes are suppressed while reset is held so an aborted access never commits.
  assign pcUpdate  = w_pc_update & ~reset;
  assign irWrite   = w_ir_write & ~reset;
  assign branch    = w_branch & ~reset;
  assign regWrite  = w_reg_write & ~reset;
  assign memWrite  = w_mem_write & ~reset;
  assign illegalOp = w_illegal & ~reset;
  assign state     = r_state;

endmodule

// File: tb/tb_main_fsm.sv
// Randomized self-checking bench for main_fsm: per-instruction state paths and a control-word
// table drive a behavioural model that is compared every cycle, plus literal directed checks.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       memReady;
  logic [3:0] state;
  logic       pcUpdate, irWrite, branch, regWrite, memWrite, adrSrc, illegalOp;
  logic [1:0] resSrc, aluSrcA, aluSrcB, aluOp, inmSrc;

  int n_checks = 0;
  int n_errors = 0;

  main_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .memReady  (memReady),
    .state     (state),
    .pcUpdate  (pcUpdate),
    .irWrite   (irWrite),
    .branch    (branch),
    .regWrite  (regWrite),
    .memWrite  (memWrite),
    .adrSrc    (adrSrc),
    .resSrc    (resSrc),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .aluOp     (aluOp),
    .inmSrc    (inmSrc),
    .illegalOp (illegalOp)
  );

  always #5 clk = ~clk;

`ifdef RV_JAL_EN
  localparam bit JalEn = 1'b1;
`else
  localparam bit JalEn = 1'b0;
`endif

  // {pcUpdate, irWrite, branch, regWrite, memWrite, adrSrc, resSrc, aluSrcA, aluSrcB, aluOp,
  //  inmSrc, illegalOp}
  localparam logic [16:0] StrobeMask = {5'b11111, 11'b0, 1'b1};

  function automatic logic [16:0] dut_ctl();
    return {pcUpdate, irWrite, branch, regWrite, memWrite, adrSrc, resSrc, aluSrcA, aluSrcB,
            aluOp, inmSrc, illegalOp};
  endfunction

  function automatic bit legal(logic [6:0] o);
    return (o == 7'd3) || (o == 7'd35) || (o == 7'd51) || (o == 7'd19) || (o == 7'd99) ||
           (JalEn && o == 7'd111);
  endfunction

  // Whole-instruction state path as nibbles (first state in the low nibble) plus its length.
  function automatic void path_of(input logic [6:0] o, output logic [31:0] code, output int len);
    case (o)
      7'd3:    begin code = 32'h43210; len = 5; end
      7'd35:   begin code = 32'h5210;  len = 4; end
      7'd51:   begin code = 32'h8610;  len = 4; end
      7'd19:   begin code = 32'h8710;  len = 4; end
      7'd99:   begin code = 32'h910;   len = 3; end
      default: begin code = 32'h10;    len = 2; end
    endcase
    if (JalEn && o == 7'd111) begin
      code = 32'h8A10;
      len  = 4;
    end
  endfunction

  function automatic logic [16:0] exp_ctl(int st, logic mr, logic [6:0] o, logic rst);
    logic pc, ir, br, rw, mw, as, il;
    logic [1:0] rs, sa, sb, ao, im;
    {pc, ir, br, rw, mw, as, il} = '0;
    {rs, sa, sb, ao} = '0;
    case (st)
      0:  begin sb = 2'd2; rs = 2'd2; ir = mr; pc = mr; end
      1:  begin sa = 2'd1; sb = 2'd1; il = !legal(o); end
      2:  begin sa = 2'd2; sb = 2'd1; end
      3:  as = 1'b1;
      4:  begin rs = 2'd1; rw = 1'b1; end
      5:  begin as = 1'b1; mw = 1'b1; end
      6:  begin sa = 2'd2; ao = 2'd2; end
      7:  begin sa = 2'd2; sb = 2'd1; ao = 2'd2; end
      8:  rw = 1'b1;
      9:  begin sa = 2'd2; ao = 2'd1; br = 1'b1; end
      10: begin sa = 2'd1; sb = 2'd2; pc = 1'b1; end
      default: ;
    endcase
    case (o)
      7'd35:   im = 2'd1;
      7'd99:   im = 2'd2;
      7'd111:  im = JalEn ? 2'd3 : 2'd0;
      default: im = 2'd0;
    endcase
    if (rst) {pc, ir, br, rw, mw, il} = '0;
    return {pc, ir, br, rw, mw, as, rs, sa, sb, ao, im, il};
  endfunction

  // Model: position within the current instruction's path.
  bit m_valid = 1'b0;
  int m_idx   = 0;

  function automatic int model_state();
    logic [31:0] code;
    int len;
    path_of(op, code, len);
    return int'((code >> (4 * m_idx)) & 32'hF);
  endfunction

  always @(negedge clk) begin
    logic [16:0] got, exp;
    logic [31:0] code;
    int len, st;
    got = dut_ctl();
    if (reset) begin
      n_checks++;
      if ((got & StrobeMask) != 17'd0) begin
        n_errors++;
        $display("FAIL reset_strobes t=%0t got=%b required=0", $time, got & StrobeMask);
      end
    end else if (m_valid) begin
      st  = model_state();
      exp = exp_ctl(st, memReady, op, 1'b0);
      n_checks++;
      if (state != 4'(st) || got != exp) begin
        n_errors++;
        $display("FAIL model t=%0t op=%0d mr=%0b state got=%0d required=%0d ctl got=%b required=%b",
                 $time, op, memReady, state, st, got, exp);
      end
    end
    if (reset) begin
      m_valid = 1'b1;
      m_idx   = 0;
    end else if (m_valid) begin
      st = model_state();
      path_of(op, code, len);
      if (!((st == 0 || st == 3 || st == 5) && !memReady)) begin
        m_idx++;
        if (m_idx >= len) m_idx = 0;
      end
    end
  end

  task automatic drive(input logic r, input logic [6:0] o, input logic mr);
    @(posedge clk);
    #1;
    reset    = r;
    op       = o;
    memReady = mr;
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, got, exp);
    end
  endtask

  initial begin
    int mw_cycles;
    reset    = 1'b1;
    op       = 7'd3;
    memReady = 1'b1;

    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 7'd3, 1'b1);
      lit("rst_state", 32'(state), 0);
      lit("rst_strobes", 32'({pcUpdate, irWrite, branch, regWrite, memWrite, illegalOp}), 0);
    end

    // lw with memReady high: 0,1,2,3,4 then park in FETCH.
    drive(1'b0, 7'd3, 1'b1);
    lit("rel_state", 32'(state), 0);
    lit("rel_irwrite", 32'(irWrite), 1);
    lit("rel_pcupdate", 32'(pcUpdate), 1);
    drive(1'b0, 7'd3, 1'b1); lit("lw_decode", 32'(state), 1);
    lit("lw_inmsrc", 32'(inmSrc), 0);
    drive(1'b0, 7'd3, 1'b1); lit("lw_memadr", 32'(state), 2);
    lit("lw_noregw", 32'(regWrite), 0);
    drive(1'b0, 7'd3, 1'b1); lit("lw_memread", 32'(state), 3);
    drive(1'b0, 7'd3, 1'b1); lit("lw_memwb", 32'(state), 4);
    lit("lw_regwrite", 32'(regWrite), 1);
    lit("lw_ressrc", 32'(resSrc), 1);
    drive(1'b0, 7'd3, 1'b0); lit("lw_back", 32'(state), 0);
    lit("fetch_wait_irw", 32'(irWrite), 0);

    // sw with three wait cycles in MEMWRITE.
    drive(1'b0, 7'd35, 1'b1); lit("sw_fetch", 32'(state), 0);
    drive(1'b0, 7'd35, 1'b1); lit("sw_inmsrc", 32'(inmSrc), 1);
    drive(1'b0, 7'd35, 1'b1); lit("sw_memadr", 32'(state), 2);
    mw_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 7'd35, (i == 3));
      lit("sw_state", 32'(state), 5);
      lit("sw_adrsrc", 32'(adrSrc), 1);
      if (memWrite) mw_cycles++;
    end
    lit("sw_memwrite_cycles", 32'(mw_cycles), 4);
    drive(1'b0, 7'd35, 1'b0); lit("sw_back", 32'(state), 0);
    lit("sw_mw_off", 32'(memWrite), 0);

    // beq.
    drive(1'b0, 7'd99, 1'b1);
    drive(1'b0, 7'd99, 1'b1); lit("beq_decode", 32'(state), 1);
    drive(1'b0, 7'd99, 1'b1); lit("beq_state", 32'(state), 9);
    lit("beq_branch", 32'(branch), 1);
    lit("beq_aluop", 32'(aluOp), 1);
    lit("beq_inmsrc", 32'(inmSrc), 2);
    drive(1'b0, 7'd99, 1'b0); lit("beq_back", 32'(state), 0);

    // Illegal opcode.
    drive(1'b0, 7'd127, 1'b1);
    drive(1'b0, 7'd127, 1'b1); lit("ill_pulse", 32'(illegalOp), 1);
    drive(1'b0, 7'd127, 1'b0); lit("ill_back", 32'(state), 0);
    lit("ill_gone", 32'(illegalOp), 0);

    // jal (path depends on build).
    drive(1'b0, 7'd111, 1'b1);
    drive(1'b0, 7'd111, 1'b1);
    lit("jal_illegal", 32'(illegalOp), JalEn ? 0 : 1);
    drive(1'b0, 7'd111, 1'b0);
    lit("jal_third", 32'(state), JalEn ? 10 : 0);
    lit("jal_pcupdate", 32'(pcUpdate), JalEn ? 1 : 0);

    // Random phase: new opcode only at instruction boundaries, random waits and resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [6:0] o;
      o = op;
      if (m_idx == 0) begin
        case ($urandom_range(0, 7))
          0: o = 7'd3;
          1: o = 7'd35;
          2: o = 7'd51;
          3: o = 7'd19;
          4: o = 7'd99;
          5: o = 7'd111;
          6: o = 7'd127;
          default: o = 7'($urandom);
        endcase
      end
      drive(($urandom_range(0, 99) == 0), o, ($urandom_range(0, 3) != 0));
    end

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
